// File: rtl/pcm_ser_out_pkg.sv
// Shared definitions for the PCM serial output block: idle codes, FSM states, LAW encoding.
package pcm_ser_out_pkg;

    localparam logic [7:0] IdleMuDefault = 8'hFF;
    localparam logic [7:0] IdleADefault  = 8'hD5;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    typedef enum logic {
        LawMu = 1'b0,
        LawA  = 1'b1
    } law_e;

    function automatic logic [7:0] idle_code(input logic law, input logic [7:0] mu,
                                             input logic [7:0] a);
        return (law == LawA) ? a : mu;
    endfunction

endpackage

// File: rtl/pcm_ser_out_fifo2.sv
// Two-entry, 8-bit FIFO feeding the serializer; pop of an empty FIFO is ignored (no bypass).
module pcm_fifo2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= 8'h00;
            mem_q[1] <= 8'h00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pcm_ser_out.sv
// PCM byte serializer: buffers codewords in a 2-deep FIFO and shifts them out MSB first on
// BIT_EN strobes, with frame sync on the MSB and an idle code substituted on underrun.
module pcm_ser_out
    import pcm_ser_out_pkg::*;
#(
    parameter logic [7:0] IDLE_MU = IdleMuDefault,
    parameter logic [7:0] IDLE_A  = IdleADefault
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sp,
    input  logic       sp_valid,
    output logic       sp_ready,
    input  logic       law,
    input  logic       bit_en,
    input  logic       clr_err,
    output logic       sdo,
    output logic       fs,
    output logic       underrun
);

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       fs_q, fs_d;
    logic       underrun_q, underrun_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic [1:0] fifo_count;
    logic       load;

    assign sp_ready  = (fifo_count < 2'd2);
    assign fifo_push = sp_valid && !fifo_full;

    pcm_fifo2 u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (sp),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The counter sits at 0 in idle, so the state must gate the first load explicitly.
    assign load = bit_en && ((state_q == StIdle) || (bit_cnt_q == 3'd7));

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        fs_d       = fs_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;

        if (load) begin
            if (!fifo_empty) begin
                shreg_d  = fifo_head;
                fifo_pop = 1'b1;
            end else begin
                shreg_d = idle_code(law, IDLE_MU, IDLE_A);
            end
            bit_cnt_d = 3'd0;
            fs_d      = 1'b1;
            state_d   = StRun;
        end else if (bit_en) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            fs_d      = 1'b0;
        end

        // A new underrun takes priority over a coincident clear.
        if (load && (state_q == StRun) && fifo_empty) begin
            underrun_d = 1'b1;
        end else if (clr_err) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

    assign sdo      = shreg_q[7];
    assign fs       = fs_q;
    assign underrun = underrun_q;

endmodule

// File: doc/pcm_ser_out.md
PCM_SER_OUT -- requirements
Module: pcm_ser_out

Interface
REQ-001 Parameter IDLE_MU, default 8'hFF: u-law idle code sent on underrun.
REQ-002 Parameter IDLE_A, default 8'hD5: A-law idle code sent on underrun.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SP  input  8  PCM codeword produced by the compress stage.
REQ-006 SP_VALID  input  1  SP holds a valid codeword this cycle.
REQ-007 SP_READY  output  1  block can accept SP this cycle.
REQ-008 LAW  input  1  0 = u-law, 1 = A-law; selects the idle code.
REQ-009 BIT_EN  input  1  one-cycle serial bit strobe; may stay high continuously.
REQ-010 CLR_ERR  input  1  clears UNDERRUN.
REQ-011 SDO  output  1  serial PCM data, MSB first, registered.
REQ-012 FS  output  1  frame sync, high during bit 7 (MSB) of every byte, registered.
REQ-013 UNDERRUN  output  1  sticky: a byte slot was filled with the idle code.

Function
REQ-014 Input buffering SHALL be a 2-entry FIFO; SP_READY = (count < 2), derived from registered count only.
REQ-015 A write SHALL occur when SP_VALID && SP_READY; SP SHALL NOT be changed or dropped after acceptance.
REQ-016 FSM states SHALL be IDLE (after reset, no byte in flight) and RUN.
REQ-017 In IDLE: SDO = 0, FS = 0; the first BIT_EN SHALL perform a load and move to RUN.
REQ-018 Load: shift register <= FIFO head if count > 0 (pop), else idle code selected by LAW sampled that cycle; bit counter <= 0; FS <= 1.
REQ-019 In RUN, on BIT_EN with bit counter = 7, SHALL perform a load; otherwise shift left by one, bit counter +1, FS <= 0.
REQ-020 SDO SHALL always equal shift register bit 7; with no BIT_EN, SDO, FS and the counter SHALL hold.
REQ-021 Latency: a byte accepted into an empty FIFO SHALL appear on SDO the cycle after the next load strobe; no bypass, so a write and a load in the same cycle with count = 0 SHALL load the idle code.
REQ-022 A simultaneous write and pop SHALL leave count unchanged and keep FIFO order.
REQ-023 A load in RUN with count = 0 SHALL set UNDERRUN; the IDLE-to-RUN first load SHALL NOT set it.
REQ-024 UNDERRUN SHALL clear on CLR_ERR; if set and clear coincide, set SHALL win.
REQ-025 Bit counter SHALL wrap 7 -> 0 only through a load; no other wrap exists.

Reset
REQ-026 RESET_N low SHALL immediately force: state IDLE, FIFO empty (count 0), shift register 0, bit counter 0, SDO 0, FS 0, UNDERRUN 0. SP_READY SHALL be 1.
REQ-027 Reset mid-byte SHALL discard the byte in flight and the FIFO contents; after release, behaviour SHALL be identical to power-up.

Structure
REQ-028 A shared package SHALL hold the default idle codes (8'hFF, 8'hD5), the FSM state encoding, and the LAW encoding (0 u-law, 1 A-law).
REQ-029 The FIFO SHALL be a sub-module pcm_fifo2 (8-bit, 2-entry, push/pop/count/full/empty); serializer and FSM SHALL stay in pcm_ser_out.

Verification
REQ-030 Reset, BIT_EN constant high, no writes, LAW=0 -> SDO serializes 8'hFF repeatedly, FS high every 8th cycle, UNDERRUN=1 from the second byte.
REQ-031 Write 8'hA5 then 8'h3C, then BIT_EN every 4 cycles -> SDO 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, one FS pulse per byte.
REQ-032 Three back-to-back writes with no BIT_EN -> first two accepted, SP_READY=0 on the third until the first load pops.
REQ-033 LAW=1, FIFO empty in RUN -> byte 8'hD5 sent, UNDERRUN=1; CLR_ERR in the same cycle as the next underrun load -> UNDERRUN stays 1.
REQ-034 RESET_N asserted at bit 3 of 8'h96 with one byte queued -> SDO=0, FS=0, SP_READY=1 immediately; next BIT_EN after release sends the idle code.
REQ-035 Write coinciding with a load strobe at count 0 -> idle code sent first, written byte sent in the following slot.
